// File: rtl/expmu_table_buffer.sv
// ---------------------------------------------------------------------------
// expmu_table_buffer
//
// Purpose:
//   Captures the (data, t, done) stream of the S0*exp(t*mu) generator into an
//   on-chip table indexed by t. The path-simulation stage reads the table
//   back at random t. The block owns fill/ready sequencing and raises oReady
//   only after a sweep has been closed by iDone.
//
// Ports:
//   CLK      in   1       single clock, rising edge
//   RST      in   1       asynchronous, active-high reset
//   iStart   in   1       arm capture (same pulse that starts upstream)
//   iData    in   DW      upstream S0*exp(t*mu) sample
//   iAddr    in   LOGT    upstream t for iData
//   iDone    in   1       upstream end-of-sweep pulse
//   iRdEn    in   1       read request
//   iRdAddr  in   LOGT    t to read
//   oRdData  out  DW      table word, one cycle after an accepted read
//   oRdValid out  1       oRdData valid
//   oReady   out  1       table complete and readable
//   oCount   out  LOGT+1  writes in current sweep (saturating)
//   oErr     out  1       sticky: short sweep, or iStart seen during FILL
//   oMax     out  DW      only with EXPMU_MAX_TRACK_EN: max data this sweep
//
// Configuration macro:
//   EXPMU_MAX_TRACK_EN  adds the oMax output and its unsigned compare logic.
//
// The table itself is never cleared by reset, so it maps onto plain RAM.
// ---------------------------------------------------------------------------
`default_nettype none

module expmu_table_buffer #(
  parameter int T_MIN = 343,
  parameter int T_MAX = 511,
  parameter int LOGT  = 9,
  parameter int DW    = 18
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            iStart,
  input  logic [DW-1:0]   iData,
  input  logic [LOGT-1:0] iAddr,
  input  logic            iDone,
  input  logic            iRdEn,
  input  logic [LOGT-1:0] iRdAddr,
  output logic [DW-1:0]   oRdData,
  output logic            oRdValid,
  output logic            oReady,
  output logic [LOGT:0]   oCount,
  output logic            oErr
`ifdef EXPMU_MAX_TRACK_EN
  ,
  output logic [DW-1:0]   oMax
`endif
);

  localparam int DEPTH = T_MAX - T_MIN + 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Range checks run one bit wider than the bus so an upper bound equal to
  // the bus maximum is still an honest comparison.
  localparam logic [LOGT:0]   T_MIN_X = T_MIN[LOGT:0];
  localparam logic [LOGT:0]   T_MAX_X = T_MAX[LOGT:0];
  localparam logic [LOGT-1:0] T_MIN_L = T_MIN[LOGT-1:0];
  localparam logic [LOGT:0]   DEPTH_X = DEPTH[LOGT:0];
  localparam logic [LOGT:0]   CNT_MAX = {1'b1, {LOGT{1'b0}}};
  localparam logic [LOGT:0]   CNT_ONE = {{LOGT{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t        state_r;
  logic [DW-1:0] mem_r [DEPTH];

  logic          wr_in_range_s;
  logic          rd_in_range_s;
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] rd_idx_s;
  logic          wr_en_s;
  logic          rd_en_s;
  logic [LOGT:0] count_nxt_s;

`ifdef EXPMU_MAX_TRACK_EN
  logic [DW-1:0] max_r;
  assign oMax = max_r;
`endif

  // Address decode, write/read qualification and next write count.
  always_comb begin
    wr_in_range_s = ({1'b0, iAddr} >= T_MIN_X) && ({1'b0, iAddr} <= T_MAX_X);
    rd_in_range_s = ({1'b0, iRdAddr} >= T_MIN_X) && ({1'b0, iRdAddr} <= T_MAX_X);
    // Offsets are only used when the range check passed, so they never wrap.
    wr_idx_s      = AW'(iAddr - T_MIN_L);
    rd_idx_s      = AW'(iRdAddr - T_MIN_L);
    wr_en_s       = (state_r == ST_FILL) && wr_in_range_s;
    rd_en_s       = (state_r == ST_READY) && iRdEn && rd_in_range_s;
    count_nxt_s   = oCount;
    if (wr_en_s && (oCount != CNT_MAX)) begin
      count_nxt_s = oCount + CNT_ONE;
    end else begin
      count_nxt_s = oCount;
    end
  end

  // Table storage: written only in FILL, no reset so it stays a RAM.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= iData;
    end
  end

  // Read port: served only in READY; data holds when no read is accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      oRdData  <= {DW{1'b0}};
      oRdValid <= 1'b0;
    end else if (rd_en_s) begin
      oRdData  <= mem_r[rd_idx_s];
      oRdValid <= 1'b1;
    end else begin
      oRdValid <= 1'b0;
    end
  end

  // Fill/ready sequencing with registered status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      oReady  <= 1'b0;
      oCount  <= {(LOGT+1){1'b0}};
      oErr    <= 1'b0;
`ifdef EXPMU_MAX_TRACK_EN
      max_r   <= {DW{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (iStart) begin
            state_r <= ST_FILL;
            oReady  <= 1'b0;
            oCount  <= {(LOGT+1){1'b0}};
`ifdef EXPMU_MAX_TRACK_EN
            max_r   <= {DW{1'b0}};
`endif
          end
        end
        ST_FILL: begin
          oCount <= count_nxt_s;
`ifdef EXPMU_MAX_TRACK_EN
          if (wr_en_s && (iData > max_r)) begin
            max_r <= iData;
          end
`endif
          // A restart request mid-fill is never honoured, only flagged.
          if (iStart) begin
            oErr <= 1'b1;
          end
          // The write of the iDone cycle is already included in count_nxt_s.
          if (iDone) begin
            state_r <= ST_READY;
            oReady  <= 1'b1;
            if (count_nxt_s < DEPTH_X) begin
              oErr <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (iStart) begin
            state_r <= ST_FILL;
            oReady  <= 1'b0;
            oCount  <= {(LOGT+1){1'b0}};
`ifdef EXPMU_MAX_TRACK_EN
            max_r   <= {DW{1'b0}};
`endif
          end else begin
            oReady  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          oReady  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_expmu_table_buffer.sv
// ---------------------------------------------------------------------------
// tb_expmu_table_buffer
//
// Directed bench for expmu_table_buffer: reset, mid-fill reset, full sweep,
// short sweep with out-of-range addresses, restart from READY with a read in
// the same cycle, iStart during FILL, and (with EXPMU_MAX_TRACK_EN) oMax.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_expmu_table_buffer;

  logic        CLK;
  logic        RST;
  logic        iStart;
  logic [17:0] iData;
  logic [8:0]  iAddr;
  logic        iDone;
  logic        iRdEn;
  logic [8:0]  iRdAddr;
  logic [17:0] oRdData;
  logic        oRdValid;
  logic        oReady;
  logic [9:0]  oCount;
  logic        oErr;
`ifdef EXPMU_MAX_TRACK_EN
  logic [17:0] oMax;
`endif

  int n_cmp;
  int n_err;

  expmu_table_buffer dut (
    .CLK      (CLK),
    .RST      (RST),
    .iStart   (iStart),
    .iData    (iData),
    .iAddr    (iAddr),
    .iDone    (iDone),
    .iRdEn    (iRdEn),
    .iRdAddr  (iRdAddr),
    .oRdData  (oRdData),
    .oRdValid (oRdValid),
    .oReady   (oReady),
    .oCount   (oCount),
    .oErr     (oErr)
`ifdef EXPMU_MAX_TRACK_EN
    ,
    .oMax     (oMax)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [8:0] t);
    iRdEn   = 1'b1;
    iRdAddr = t;
    tick();
    iRdEn   = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    RST     = 1'b1;
    iStart  = 1'b0;
    iData   = 18'd0;
    iAddr   = 9'd0;
    iDone   = 1'b0;
    iRdEn   = 1'b0;
    iRdAddr = 9'd0;
    repeat (3) tick();
    RST = 1'b0;
    tick();

    // Reset state
    chk("rst_ready",   32'(oReady),   32'd0);
    chk("rst_rdvalid", 32'(oRdValid), 32'd0);
    chk("rst_rddata",  32'(oRdData),  32'd0);
    chk("rst_count",   32'(oCount),   32'd0);
    chk("rst_err",     32'(oErr),     32'd0);

    // Reset in the middle of a fill after 50 writes
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int a = 343; a < 393; a++) begin
      iAddr = 9'(a);
      iData = 18'(a);
      tick();
    end
    chk("midfill_count50", 32'(oCount), 32'd50);
    iAddr = 9'd360;
    RST   = 1'b1;
    #2;
    chk("async_rst_ready", 32'(oReady), 32'd0);
    chk("async_rst_count", 32'(oCount), 32'd0);
    chk("async_rst_err",   32'(oErr),   32'd0);
    tick();
    tick();
    RST = 1'b0;
    for (int a = 343; a < 348; a++) begin
      iAddr = 9'(a);
      iData = 18'(a);
      tick();
    end
    chk("idle_no_count", 32'(oCount), 32'd0);
    chk("idle_no_ready", 32'(oReady), 32'd0);
    iAddr = 9'd0;
    rd(9'd343);
    chk("idle_read_invalid", 32'(oRdValid), 32'd0);

    // Full sweep 343..511 with iData = iAddr
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("fill_entry_ready", 32'(oReady), 32'd0);
    chk("fill_entry_count", 32'(oCount), 32'd0);
    for (int a = 343; a <= 511; a++) begin
      iAddr = 9'(a);
      iData = 18'(a);
      iDone = (a == 511);
      tick();
    end
    iDone = 1'b0;
    iAddr = 9'd0;
    chk("full_count",  32'(oCount), 32'd169);
    chk("full_ready",  32'(oReady), 32'd1);
    chk("full_err",    32'(oErr),   32'd0);
`ifdef EXPMU_MAX_TRACK_EN
    chk("full_max",    32'(oMax),   32'd511);
`endif
    chk("pre_read_valid", 32'(oRdValid), 32'd0);
    rd(9'd400);
    chk("rd400_valid", 32'(oRdValid), 32'd1);
    chk("rd400_data",  32'(oRdData),  32'd400);
    tick();
    chk("rd400_valid_drop", 32'(oRdValid), 32'd0);
    chk("rd400_data_hold",  32'(oRdData),  32'd400);
    rd(9'd342);
    chk("rd342_invalid", 32'(oRdValid), 32'd0);
    chk("rd342_hold",    32'(oRdData),  32'd400);
    rd(9'd511);
    chk("rd511_data", 32'(oRdData), 32'd511);
    rd(9'd343);
    chk("rd343_data", 32'(oRdData), 32'd343);

    // Restart from READY with a read in the same cycle
    iStart  = 1'b1;
    iRdEn   = 1'b1;
    iRdAddr = 9'd450;
    tick();
    iStart  = 1'b0;
    iRdEn   = 1'b0;
    chk("restart_rd_valid", 32'(oRdValid), 32'd1);
    chk("restart_rd_data",  32'(oRdData),  32'd450);
    chk("restart_ready",    32'(oReady),   32'd0);
    chk("restart_count",    32'(oCount),   32'd0);

    // Short second sweep 343..450 with iData = t + 1000, plus out-of-range t
    for (int a = 343; a <= 400; a++) begin
      iAddr = 9'(a);
      iData = 18'(a + 1000);
      tick();
    end
    chk("short_count58", 32'(oCount), 32'd58);
    iAddr = 9'd342;
    iData = 18'd7;
    tick();
    iAddr = 9'd0;   // t=512 does not fit the 9-bit bus and arrives as 0
    tick();
    chk("oor_no_count", 32'(oCount), 32'd58);
    for (int a = 401; a <= 450; a++) begin
      iAddr = 9'(a);
      iData = 18'(a + 1000);
      iDone = (a == 450);
      tick();
    end
    iDone = 1'b0;
    iAddr = 9'd0;
    chk("short_ready", 32'(oReady), 32'd1);
    chk("short_count", 32'(oCount), 32'd108);
    chk("short_err",   32'(oErr),   32'd1);
    rd(9'd400);
    chk("rd400_overwritten", 32'(oRdData), 32'd1400);
    rd(9'd450);
    chk("rd450_overwritten", 32'(oRdData), 32'd1450);
    rd(9'd451);
    chk("rd451_old_sweep",   32'(oRdData), 32'd451);

    // iStart during FILL, then iStart together with iDone
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    chk("rst2_err", 32'(oErr), 32'd0);
    iStart = 1'b1;
    tick();
    iAddr  = 9'd343;
    iData  = 18'd5;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("start_in_fill_err",   32'(oErr),   32'd1);
    chk("start_in_fill_count", 32'(oCount), 32'd1);
    chk("start_in_fill_ready", 32'(oReady), 32'd0);
    iAddr = 9'd344;
    iData = 18'd90000;
    tick();
    iAddr  = 9'd345;
    iData  = 18'd7;
    iStart = 1'b1;
    iDone  = 1'b1;
    tick();
    iStart = 1'b0;
    iDone  = 1'b0;
    iAddr  = 9'd0;
    chk("done_wins_ready", 32'(oReady), 32'd1);
    chk("done_wins_err",   32'(oErr),   32'd1);
    chk("done_wins_count", 32'(oCount), 32'd3);
`ifdef EXPMU_MAX_TRACK_EN
    chk("max_90000",       32'(oMax),   32'd90000);
`endif
    rd(9'd344);
    chk("rd344_data", 32'(oRdData), 32'd90000);
    rd(9'd345);
    chk("rd345_data", 32'(oRdData), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
